id_ex_hazard_stage: RTL

//  ID/EX pipeline register plus load-use hazard detection for the 5-stage MIPS core.

---
 rtl/id_ex_hazard_stage_if.sv | 27 ++
 rtl/id_ex_hazard_stage.sv | 46 ++++
 2 files changed

// File: rtl/id_ex_hazard_stage_if.sv
// id_ex_hazard_stage_if: ID-side inputs and EX-side outputs of the ID/EX stage
interface id_ex_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [0:7]        id_ctrl;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc;
  logic              hold, flush, cnt_clr;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [0:7]        ex_ctrl;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc;
  logic              pc_write, ifid_write;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_rs, id_rt, id_rd, id_ctrl, id_rdata1, id_rdata2, id_imm, id_pc,
           hold, flush, cnt_clr,
    input  ex_rs, ex_rt, ex_rd, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm, ex_pc,
           pc_write, ifid_write, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_rd, id_ctrl, id_rdata1, id_rdata2, id_imm, id_pc,
           hold, flush, cnt_clr,
    output ex_rs, ex_rt, ex_rd, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm, ex_pc,
           pc_write, ifid_write, stall_cnt
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use bubble insertion and stall counter
module id_ex_hazard_stage #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int MEMREAD_BIT = 2
) (
  input logic clk,
  input logic rst,
  id_ex_hazard_stage_if.slave b
);
  logic lu, bubble;
  // a load in EX whose destination is read by the instruction in ID cannot forward in time
  always_comb begin
    lu = b.ex_ctrl[MEMREAD_BIT] && (b.ex_rt != 5'd0) && (b.ex_rt == b.id_rs || b.ex_rt == b.id_rt);
    bubble = b.flush || lu;
    b.pc_write = rst && !b.hold && (b.flush || !lu);
    b.ifid_write = b.pc_write;
  end
  // EX registers: freeze on hold, bubble on flush or load-use, otherwise capture ID
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      b.ex_rs <= '0;
      b.ex_rt <= '0;
      b.ex_rd <= '0;
      b.ex_ctrl <= '0;
      b.ex_rdata1 <= '0;
      b.ex_rdata2 <= '0;
      b.ex_imm <= '0;
      b.ex_pc <= '0;
    end else if (!b.hold) begin
      b.ex_rs <= bubble ? '0 : b.id_rs;
      b.ex_rt <= bubble ? '0 : b.id_rt;
      b.ex_rd <= bubble ? '0 : b.id_rd;
      b.ex_ctrl <= bubble ? '0 : b.id_ctrl;
      b.ex_rdata1 <= bubble ? '0 : b.id_rdata1;
      b.ex_rdata2 <= bubble ? '0 : b.id_rdata2;
      b.ex_imm <= bubble ? '0 : b.id_imm;
      b.ex_pc <= bubble ? '0 : b.id_pc;
    end
  // saturating count of load-use bubbles; clear wins over a same-edge increment
  always_ff @(posedge clk or negedge rst)
    if (!rst) b.stall_cnt <= '0;
    else if (!b.hold)
      b.stall_cnt <= b.cnt_clr ? '0 :
                     (lu && !b.flush && b.stall_cnt != '1) ? b.stall_cnt + 1'b1 : b.stall_cnt;
endmodule
